// File: rtl/regfile_read_arbiter_if.sv
// Bundle between the register-file read arbiter and its requesters and read mux.
// The slave side is the arbiter; the master side is the requester/mux environment.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [DATA_W-1:0]         mux_data;
  logic [ADDR_W-1:0]         reg_sel;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic [ID_W-1:0]           gnt_id;
  logic                      busy;

  modport master (
    output req, addr, mux_data,
    input  reg_sel, ack, rdata, gnt_id, busy
  );

  modport slave (
    input  req, addr, mux_data,
    output reg_sel, ack, rdata, gnt_id, busy
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NUM_REQ requesters.
// Each transaction takes three cycles: grant (IDLE), mux settle/capture (SEL), ack pulse (ACK).
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_read_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   reg_sel_r;
  logic [NUM_REQ-1:0]  ack_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [ID_W-1:0]     gnt_id_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic                busy_r;

  logic [ID_W-1:0]     winner_s;
  logic                found_s;
  logic [ADDR_W-1:0]   win_addr_s;

  // Round-robin pick: first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner_s = {ID_W{1'b0}};
    found_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [ID_W-1:0] idx_v;
      idx_v = ID_W'(rr_ptr_r + i);
      if (!found_s && bus.req[idx_v]) begin
        winner_s = idx_v;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
    win_addr_s = bus.addr[winner_s*ADDR_W +: ADDR_W];
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      reg_sel_r <= {ADDR_W{1'b0}};
      ack_r     <= {NUM_REQ{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      gnt_id_r  <= {ID_W{1'b0}};
      rr_ptr_r  <= {ID_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= {NUM_REQ{1'b0}};
          if (found_s) begin
            reg_sel_r <= win_addr_s;
            gnt_id_r  <= winner_s;
            rr_ptr_r  <= winner_s + {{(ID_W-1){1'b0}}, 1'b1};
            busy_r    <= 1'b1;
            state_r   <= ST_SEL;
          end else begin
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        // The mux has had a full cycle on reg_sel; capture and acknowledge regardless of req.
        ST_SEL: begin
          rdata_r <= bus.mux_data;
          ack_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_r;
          busy_r  <= 1'b1;
          state_r <= ST_ACK;
        end
        ST_ACK: begin
          ack_r   <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r   <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.reg_sel = reg_sel_r;
  assign bus.ack     = ack_r;
  assign bus.rdata   = rdata_r;
  assign bus.gnt_id  = gnt_id_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared each cycle
// against a transaction-level reference model (grant time, round-robin pointer, mux contents).
module tb_regfile_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DW-1:0] regs_mem [16];
  assign bus.mux_data = regs_mem[bus.reg_sel];

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a grant at edge g gives ack after edge g+1 and frees the arbiter at edge g+3.
  int          cyc;
  int          m_gcyc;
  int          m_rr;
  int          m_gnt;
  int          m_sel;
  logic [N-1:0]  m_ack;
  logic [DW-1:0] m_rdata;
  logic          m_busy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_gcyc = -10; m_rr = 0; m_gnt = 0; m_sel = 0;
    m_ack = '0; m_rdata = '0; m_busy = 1'b0;
  endtask

  task automatic model_edge();
    int  w;
    bit  hit;
    if (cyc >= m_gcyc + 3 && (|bus.req)) begin
      hit = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!hit && bus.req[i]) begin w = i; hit = 1; end
      end
      m_sel  = int'(bus.addr[w*AW +: AW]);
      m_gnt  = w;
      m_rr   = (w + 1) % N;
      m_gcyc = cyc;
    end
    m_ack = '0;
    if (cyc == m_gcyc + 1) begin
      m_ack[m_gnt] = 1'b1;
      m_rdata      = regs_mem[m_sel];
    end
    m_busy = (cyc == m_gcyc) || (cyc == m_gcyc + 1);
    cyc++;
  endtask

  task automatic check_all();
    check_eq("reg_sel", 32'(bus.reg_sel), 32'(m_sel));
    check_eq("gnt_id",  32'(bus.gnt_id),  32'(m_gnt));
    check_eq("ack",     32'(bus.ack),     32'(m_ack));
    check_eq("rdata",   32'(bus.rdata),   32'(m_rdata));
    check_eq("busy",    32'(bus.busy),    32'(m_busy));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_reg_sel"}, 32'(bus.reg_sel), 32'd0);
    check_eq({tag, "_ack"},     32'(bus.ack),     32'd0);
    check_eq({tag, "_rdata"},   32'(bus.rdata),   32'd0);
    check_eq({tag, "_gnt_id"},  32'(bus.gnt_id),  32'd0);
    check_eq({tag, "_busy"},    32'(bus.busy),    32'd0);
  endtask

  // Asynchronous reset raised and released between clock edges.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    #1 rst = 1'b0;
  endtask

  function automatic int ack_index(input logic [N-1:0] a);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (a[i]) r = i;
    return r;
  endfunction

  initial begin
    int order[$];
    int cnt[N];
    bus.req  = '0;
    bus.addr = '0;
    for (int i = 0; i < 16; i++) regs_mem[i] = 16'hA000 | 16'(i);
    model_reset();

    // 1: reset, then idle with no requests
    do_reset("rst1");
    repeat (4) cycle();

    // 2: single request, address 5
    bus.req = 4'b0001;
    bus.addr[0 +: AW] = 4'h5;
    cycle();
    check_eq("t2_sel_c1", 32'(bus.reg_sel), 32'h5);
    cycle();
    check_eq("t2_ack_c2",   32'(bus.ack),   32'h1);
    check_eq("t2_rdata_c2", 32'(bus.rdata), 32'hA005);
    cycle();
    bus.req = '0;
    repeat (2) cycle();

    // 3: all four request after reset; each drops after its ack
    do_reset("rst3");
    for (int i = 0; i < N; i++) bus.addr[i*AW +: AW] = 4'(i + 8);
    bus.req = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (|bus.ack) begin
        order.push_back(ack_index(bus.ack));
        check_eq("t3_rdata", 32'(bus.rdata), 32'(16'hA008 + 16'(order.size() - 1)));
        bus.req = bus.req & ~bus.ack;
      end
    end
    check_eq("t3_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size(); k++) check_eq("t3_order", 32'(order[k]), 32'(k));

    // 4: requesters 0 and 2 held continuously
    do_reset("rst4");
    bus.req = 4'b0101;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    order.delete();
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (|bus.ack) begin
        cnt[ack_index(bus.ack)]++;
        order.push_back(ack_index(bus.ack));
      end
    end
    check_eq("t4_cnt0", 32'(cnt[0]), 32'd2);
    check_eq("t4_cnt1", 32'(cnt[1]), 32'd0);
    check_eq("t4_cnt2", 32'(cnt[2]), 32'd2);
    check_eq("t4_cnt3", 32'(cnt[3]), 32'd0);
    for (int k = 0; k < order.size(); k++) check_eq("t4_alt", 32'(order[k]), 32'((k % 2) * 2));
    bus.req = '0;
    repeat (3) cycle();

    // 5: requester 1 drops req during SEL; transaction still completes
    bus.addr[1*AW +: AW] = 4'h3;
    bus.req = 4'b0010;
    cycle();
    bus.req = '0;
    cycle();
    check_eq("t5_ack",   32'(bus.ack),   32'h2);
    check_eq("t5_rdata", 32'(bus.rdata), 32'hA003);
    cycle();
    check_eq("t5_busy",  32'(bus.busy),  32'd0);
    cycle();

    // 6: reset during SEL, then sole requester 3, then everyone after another reset
    bus.addr[2*AW +: AW] = 4'h7;
    bus.req = 4'b0100;
    cycle();
    check_eq("t6_busy_sel", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1 check_zero("t6_mid");
    model_reset();
    #1 rst = 1'b0;
    bus.req = 4'b1000;
    bus.addr[3*AW +: AW] = 4'hE;
    cycle();
    check_eq("t6_gnt3", 32'(bus.gnt_id), 32'd3);
    cycle();
    check_eq("t6_ack3", 32'(bus.ack), 32'h8);
    cycle();
    bus.req = '0;
    do_reset("rst6");
    bus.req = 4'b1111;
    cycle();
    check_eq("t6_gnt0", 32'(bus.gnt_id), 32'd0);
    repeat (2) cycle();

    // Randomized traffic with random mux contents
    for (int i = 0; i < 16; i++) regs_mem[i] = 16'($urandom);
    for (int c = 0; c < 600; c++) begin
      bus.req  = 4'($urandom_range(0, 15));
      bus.addr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req = '0;
      cycle();
      if (c == 300) do_reset("rst_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
